// File: rtl/cbt_cal_pkg.sv
// Shared definitions for the CBT calibration plateau-threshold sequencer:
// divider widths, the derived expected-stable-window constant and the FSM states.
package cbt_cal_pkg;

   localparam int kDivDW = 24;   // divider operand / quotient integer width
   localparam int kDivQF = 8;    // divider quotient fraction width
   localparam int kTapW  = 24;   // Q16.8 tap delay width

   localparam int  kFreqFastClkDef = 500;
   localparam real kStableRangeDef = 0.65;

   // Stable window in ps: half a fast-clock period scaled by the stable fraction,
   // truncated toward zero.
   function automatic int stable_length_ps(input int freq_mhz, input real range);
      return $rtoi(1.0e6 / (2.0 * freq_mhz) * range);
   endfunction

   localparam int kExpectedStableLength = stable_length_ps(kFreqFastClkDef, kStableRangeDef);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHECK,
      S_ISSUE_M,
      S_WAIT_M,
      S_ISSUE_S,
      S_WAIT_S,
      S_SUM,
      S_ISSUE_T,
      S_WAIT_T,
      S_FINISH,
      S_FAIL
   } cal_state_e;

endpackage

// File: rtl/cal_plateau_sequencer.sv
// Plateau-threshold sequencer: runs master tap, slave tap and threshold
// divisions one after another on a single shared AXI-stream divider.
module cal_plateau_sequencer
   import cbt_cal_pkg::*;
#(
   parameter int  kCNTVALUEbit = 9,
   parameter int  kNumTaps     = 32,
   parameter int  kDELAY_VALUE = 1000,
   parameter int  kAlignDelay  = 54,
   parameter real kStableRange = 0.65,
   parameter int  kFreqFastClk = 500,
   parameter int  kBitPut      = 4,
   parameter int  kDivTapShift = 8,
   parameter int  kDivTimeout  = 255
)(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    start,
   input  logic [kCNTVALUEbit-1:0] cntValueOutInit,
   input  logic [kCNTVALUEbit-1:0] cntValueOutSlaveInit,
   output logic                    busy,
   output logic                    done,
   output logic                    valid,
   output logic                    error,
   output logic [kNumTaps-1:0]     plateauThreshold,
   output logic                    div_s_tvalid,
   input  logic                    div_s_tready,
   output logic [kDivDW-1:0]       div_dividend,
   output logic [kDivDW-1:0]       div_divisor,
   input  logic                    div_m_tvalid,
   output logic                    div_m_tready,
   input  logic [kDivDW-1:0]       div_q_int,
   input  logic [kDivQF-1:0]       div_q_frac,
   input  logic                    div_by_zero
);

   localparam int kExpLen = stable_length_ps(kFreqFastClk, kStableRange);
   localparam int kTmoW   = $clog2(kDivTimeout + 1);

   localparam logic [15:0]             kDelay16  = 16'(kDELAY_VALUE);
   localparam logic [kDivDW-1:0]       kTapDvd   = kDivDW'(kDelay16);
   localparam logic [kDivDW-1:0]       kThrDvd   = kDivDW'(kExpLen << kDivTapShift);
   localparam logic [kCNTVALUEbit-1:0] kAlign    = kCNTVALUEbit'(kAlignDelay);
   localparam logic [kTmoW-1:0]        kTmoLimit = kTmoW'(kDivTimeout);

   cal_state_e                state_q, state_d;
   logic [kCNTVALUEbit-1:0]   cnt_m_q, cnt_m_d, cnt_s_q, cnt_s_d;
   logic [kTapW-1:0]          tap_m_q, tap_m_d, tap_s_q, tap_s_d, tap_sum;
   logic [kDivDW-1:0]         dvs_t_q, dvs_t_d;
   logic [kTmoW-1:0]          tmo_q, tmo_d;
   logic [kNumTaps-1:0]       thr_q, thr_d;
   logic                      valid_q, valid_d, error_q, error_d;
   logic                      tmo_hit;

   assign busy             = (state_q != S_IDLE);
   assign done             = (state_q == S_FINISH) || (state_q == S_FAIL);
   assign valid            = valid_q;
   assign error            = error_q;
   assign plateauThreshold = thr_q;
   assign div_s_tvalid     = (state_q == S_ISSUE_M) || (state_q == S_ISSUE_S) || (state_q == S_ISSUE_T);
   assign div_m_tready     = (state_q == S_WAIT_M) || (state_q == S_WAIT_S) || (state_q == S_WAIT_T);
   assign tmo_hit          = (tmo_q == kTmoLimit);
   assign tap_sum          = tap_m_q + tap_s_q;

   // Control state and published status; reset aborts any run without a done pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
         thr_q   <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         thr_q   <= thr_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   // Latched counts and intermediate taps only matter within a run, so they need no reset.
   always_ff @(posedge CLK) begin
      cnt_m_q <= cnt_m_d;
      cnt_s_q <= cnt_s_d;
      tap_m_q <= tap_m_d;
      tap_s_q <= tap_s_d;
      dvs_t_q <= dvs_t_d;
   end

   // Next-state logic: one division at a time, timeout measured from each request.
   // Results and the error flag are written on the way into FINISH/FAIL so they
   // are already valid in the cycle done is high.
   always_comb begin
      state_d = state_q;
      cnt_m_d = cnt_m_q;
      cnt_s_d = cnt_s_q;
      tap_m_d = tap_m_q;
      tap_s_d = tap_s_q;
      dvs_t_d = dvs_t_q;
      tmo_d   = tmo_q;
      thr_d   = thr_q;
      valid_d = valid_q;
      error_d = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_m_d = cntValueOutInit;
               cnt_s_d = cntValueOutSlaveInit;
               valid_d = 1'b0;
               error_d = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if ((cnt_m_q <= kAlign) || (cnt_s_q == '0)) begin
               error_d = 1'b1;
               state_d = S_FAIL;
            end else begin
               tmo_d   = '0;
               state_d = S_ISSUE_M;
            end
         end
         S_ISSUE_M, S_ISSUE_S, S_ISSUE_T: begin
            tmo_d = tmo_q + kTmoW'(1);
            if (div_s_tready) begin
               if (state_q == S_ISSUE_M)      state_d = S_WAIT_M;
               else if (state_q == S_ISSUE_S) state_d = S_WAIT_S;
               else                           state_d = S_WAIT_T;
            end else if (tmo_hit) begin
               error_d = 1'b1;
               state_d = S_FAIL;
            end
         end
         S_WAIT_M, S_WAIT_S, S_WAIT_T: begin
            tmo_d = tmo_q + kTmoW'(1);
            if (div_m_tvalid) begin
               if (div_by_zero) begin
                  error_d = 1'b1;
                  state_d = S_FAIL;
               end else if (state_q == S_WAIT_M) begin
                  tap_m_d = {div_q_int[15:0], div_q_frac};
                  tmo_d   = '0;
                  state_d = S_ISSUE_S;
               end else if (state_q == S_WAIT_S) begin
                  tap_s_d = {div_q_int[15:0], div_q_frac};
                  state_d = S_SUM;
               end else begin
                  thr_d   = kNumTaps'(div_q_int);
                  valid_d = 1'b1;
                  state_d = S_FINISH;
               end
            end else if (tmo_hit) begin
               error_d = 1'b1;
               state_d = S_FAIL;
            end
         end
         S_SUM: begin
            dvs_t_d = kDivDW'(tap_sum << kBitPut);
            tmo_d   = '0;
            state_d = S_ISSUE_T;
         end
         S_FINISH, S_FAIL: state_d = S_IDLE;
         default:          state_d = S_IDLE;
      endcase
   end

   // Operands are presented only while a request is outstanding.
   always_comb begin
      div_dividend = '0;
      div_divisor  = '0;
      case (state_q)
         S_ISSUE_M: begin
            div_dividend = kTapDvd;
            div_divisor  = kDivDW'(cnt_m_q - kAlign);
         end
         S_ISSUE_S: begin
            div_dividend = kTapDvd;
            div_divisor  = kDivDW'(cnt_s_q);
         end
         S_ISSUE_T: begin
            div_dividend = kThrDvd;
            div_divisor  = dvs_t_q;
         end
         default: ;
      endcase
   end

endmodule
